vga_palette_pipe: RTL and testbench

VGA_PALETTE_PIPE -- requirements
Module: vga_palette_pipe

---
 rtl/ogege_pkg.sv | 18 +
 rtl/palette_ram.sv | 30 +++
 rtl/vga_palette_pipe.sv | 140 ++++++++++++++
 tb/tb_vga_palette_pipe.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/ogege_pkg.sv
// Shared definitions for the VGA palette pipeline.
// Display geometry, colour type and default palette contents.
package ogege_pkg;

    localparam int HRES   = 640;
    localparam int VRES   = 480;
    localparam int HSZ    = $clog2(HRES);
    localparam int VSZ    = $clog2(VRES);
    localparam int ADDR_W = 17;

    typedef logic [11:0] rgb12;

    // Grayscale ramp: entry i holds {i,i,i}
    function automatic rgb12 default_pal(input logic [3:0] idx);
        return {idx, idx, idx};
    endfunction

endpackage

// File: rtl/palette_ram.sv
// 16-entry 12-bit colour palette held in flops.
// One synchronous write port, one combinational read port.
module palette_ram
    import ogege_pkg::*;
(
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic       we_i,
    input  logic [3:0] wr_idx_i,
    input  rgb12       wr_rgb_i,
    input  logic [3:0] rd_idx_i,
    output rgb12       rd_rgb_o
);

    rgb12 mem [16];

    // Entries reload the grayscale ramp on reset, else take writes
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < 16; i++) begin
                mem[i] <= default_pal(4'(i));
            end
        end else if (we_i) begin
            mem[wr_idx_i] <= wr_rgb_i;
        end
    end

    assign rd_rgb_o = mem[rd_idx_i];

endmodule

// File: rtl/vga_palette_pipe.sv
// 4bpp framebuffer fetch, palette lookup and sync alignment.
// Vertical scroll is latched at the first blank line of a frame.
module vga_palette_pipe
    import ogege_pkg::*;
#(
    parameter int HRES   = ogege_pkg::HRES,
    parameter int VRES   = ogege_pkg::VRES,
    parameter int HSZ    = $clog2(HRES),
    parameter int VSZ    = $clog2(VRES),
    parameter int ADDR_W = ogege_pkg::ADDR_W
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic [HSZ-1:0]    hcount_i,
    input  logic [VSZ-1:0]    vcount_i,
    input  logic              de_i,
    input  logic              hsync_i,
    input  logic              vsync_i,
    output logic [ADDR_W-1:0] fb_addr_o,
    input  logic [15:0]       fb_data_i,
    input  logic              pal_we_i,
    input  logic [3:0]        pal_idx_i,
    input  logic [11:0]       pal_rgb_i,
    input  logic              scroll_we_i,
    input  logic [VSZ-1:0]    scroll_i,
    output logic [3:0]        r_o,
    output logic [3:0]        g_o,
    output logic [3:0]        b_o,
    output logic              de_o,
    output logic              hsync_o,
    output logic              vsync_o
);

    // Framebuffer words per line (4 pixels per word)
    localparam logic [31:0] WPL = 32'(HRES / 4);

    // Constant multiply by WPL built from shifted copies
    function automatic logic [ADDR_W-1:0] line_base(
        input logic [VSZ-1:0] line
    );
        logic [ADDR_W-1:0] acc;
        acc = '0;
        for (int b = 0; b < 32; b++) begin
            if (WPL[b]) begin
                acc = acc + (ADDR_W'(line) << b);
            end
        end
        return acc;
    endfunction

    logic [VSZ-1:0] scroll_pend;
    logic [VSZ-1:0] scroll_act;
    logic           scroll_ok;
    logic           apply;
    logic [VSZ:0]   line_sum;
    logic [VSZ-1:0] eff_line;

    logic           de1;
    logic           hs1;
    logic           vs1;
    logic [1:0]     sel1;
    logic [3:0]     nib;
    rgb12           pal_rgb;
    rgb12           rgb2;

    assign scroll_ok = scroll_we_i && (scroll_i < VSZ'(VRES));
    assign apply     = (hcount_i == '0) && (vcount_i == VSZ'(VRES));

    assign line_sum = {1'b0, vcount_i} + {1'b0, scroll_act};
    assign eff_line = (line_sum >= (VSZ+1)'(VRES))
                    ? VSZ'(line_sum - (VSZ+1)'(VRES))
                    : line_sum[VSZ-1:0];

    assign fb_addr_o = de_i
                     ? line_base(eff_line)
                       + ADDR_W'(hcount_i[HSZ-1:2])
                     : '0;

    // Pending scroll takes writes; active scroll updates at frame end
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            scroll_pend <= '0;
            scroll_act  <= '0;
        end else begin
            if (scroll_ok) begin
                scroll_pend <= scroll_i;
            end
            if (apply) begin
                scroll_act <= scroll_ok ? scroll_i : scroll_pend;
            end
        end
    end

    // Stage 1: hold timing while the framebuffer word is fetched
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            de1  <= 1'b0;
            hs1  <= 1'b0;
            vs1  <= 1'b0;
            sel1 <= 2'd0;
        end else begin
            de1  <= de_i;
            hs1  <= hsync_i;
            vs1  <= vsync_i;
            sel1 <= hcount_i[1:0];
        end
    end

    assign nib = fb_data_i[{sel1, 2'b00} +: 4];

    palette_ram u_pal (
        .clk_i    (clk_i),
        .rstn_i   (rstn_i),
        .we_i     (pal_we_i),
        .wr_idx_i (pal_idx_i),
        .wr_rgb_i (pal_rgb_i),
        .rd_idx_i (nib),
        .rd_rgb_o (pal_rgb)
    );

    // Stage 2: register colour (blanked outside display) and timing
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rgb2    <= '0;
            de_o    <= 1'b0;
            hsync_o <= 1'b0;
            vsync_o <= 1'b0;
        end else begin
            rgb2    <= de1 ? pal_rgb : '0;
            de_o    <= de1;
            hsync_o <= hs1;
            vsync_o <= vs1;
        end
    end

    assign r_o = rgb2[11:8];
    assign g_o = rgb2[7:4];
    assign b_o = rgb2[3:0];

endmodule

// File: tb/tb_vga_palette_pipe.sv
// Randomized bench for vga_palette_pipe against a frame-level model.
// Model: addresses from (line+scroll) mod VRES, 2-cycle output queue.
module tb_vga_palette_pipe;

    localparam int HR = 640;
    localparam int VR = 480;

    logic        clk = 1'b0;
    logic        rstn_i = 1'b0;
    logic [9:0]  hcount_i = '0;
    logic [8:0]  vcount_i = '0;
    logic        de_i = 1'b0;
    logic        hsync_i = 1'b0;
    logic        vsync_i = 1'b0;
    logic [16:0] fb_addr_o;
    logic [15:0] fb_data_i = '0;
    logic        pal_we_i = 1'b0;
    logic [3:0]  pal_idx_i = '0;
    logic [11:0] pal_rgb_i = '0;
    logic        scroll_we_i = 1'b0;
    logic [8:0]  scroll_i = '0;
    logic [3:0]  r_o;
    logic [3:0]  g_o;
    logic [3:0]  b_o;
    logic        de_o;
    logic        hsync_o;
    logic        vsync_o;

    vga_palette_pipe dut (
        .clk_i       (clk),
        .rstn_i      (rstn_i),
        .hcount_i    (hcount_i),
        .vcount_i    (vcount_i),
        .de_i        (de_i),
        .hsync_i     (hsync_i),
        .vsync_i     (vsync_i),
        .fb_addr_o   (fb_addr_o),
        .fb_data_i   (fb_data_i),
        .pal_we_i    (pal_we_i),
        .pal_idx_i   (pal_idx_i),
        .pal_rgb_i   (pal_rgb_i),
        .scroll_we_i (scroll_we_i),
        .scroll_i    (scroll_i),
        .r_o         (r_o),
        .g_o         (g_o),
        .b_o         (b_o),
        .de_o        (de_o),
        .hsync_o     (hsync_o),
        .vsync_o     (vsync_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    int fb_mode = 0;

    function automatic int fbword(input int a);
        case (fb_mode)
            0:       return 'h3210;
            1:       return 'h5555;
            default: return ((a * 40503) ^ (a >> 5)) & 'hFFFF;
        endcase
    endfunction

    // Framebuffer memory: word returned one cycle after its address
    always @(posedge clk) fb_data_i <= 16'(fbword(int'(fb_addr_o)));

    int pal_m [16];
    int act_m = 0;
    int pend_m = 0;
    int s1_de = 0, s1_hs = 0, s1_vs = 0, s1_nib = 0;
    int e_de = 0, e_hs = 0, e_vs = 0, e_rgb = 0;

    task automatic model_reset();
        for (int i = 0; i < 16; i++) pal_m[i] = i * 'h111;
        act_m = 0;
        pend_m = 0;
        s1_de = 0; s1_hs = 0; s1_vs = 0; s1_nib = 0;
        e_de = 0; e_hs = 0; e_vs = 0; e_rgb = 0;
    endtask

    function automatic int addr_m(input int h, input int v, input int de);
        if (de == 0) return 0;
        return ((v + act_m) % VR) * (HR / 4) + h / 4;
    endfunction

    task automatic cyc(input int h, input int v, input int de,
                       input int hs, input int vs, input int rn,
                       input int pwe, input int pidx, input int prgb,
                       input int swe, input int s);
        int a;
        @(negedge clk);
        chk("r", r_o, (e_rgb >> 8) & 'hF);
        chk("g", g_o, (e_rgb >> 4) & 'hF);
        chk("b", b_o, e_rgb & 'hF);
        chk("de", de_o, e_de);
        chk("hsync", hsync_o, e_hs);
        chk("vsync", vsync_o, e_vs);
        if (rn != 0) begin
            e_de = s1_de; e_hs = s1_hs; e_vs = s1_vs;
            e_rgb = (s1_de != 0) ? pal_m[s1_nib] : 0;
        end
        rstn_i = rn[0];
        hcount_i = 10'(h);
        vcount_i = 9'(v);
        de_i = de[0];
        hsync_i = hs[0];
        vsync_i = vs[0];
        pal_we_i = pwe[0];
        pal_idx_i = 4'(pidx);
        pal_rgb_i = 12'(prgb);
        scroll_we_i = swe[0];
        scroll_i = 9'(s);
        if (rn == 0) model_reset();
        #1;
        a = addr_m(h, v, de);
        chk("fb_addr", fb_addr_o, a);
        if (rn != 0) begin
            s1_de = de; s1_hs = hs; s1_vs = vs;
            s1_nib = (fbword(a) >> (4 * (h % 4))) & 'hF;
            if (pwe != 0) pal_m[pidx] = prgb;
            if (h == 0 && v == VR)
                act_m = (swe != 0 && s < VR) ? s : pend_m;
            if (swe != 0 && s < VR) pend_m = s;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(700, 490, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    endtask

    task automatic rand_line(input int v, input int n);
        int h0;
        h0 = $urandom_range(0, HR - 1 - n);
        for (int i = 0; i < n; i++) begin
            cyc(h0 + i, v, int'($urandom_range(0, 3) != 0),
                int'($urandom_range(0, 1)), int'($urandom_range(0, 1)), 1,
                int'($urandom_range(0, 7) == 0), int'($urandom_range(0, 15)),
                int'($urandom_range(0, 4095)), 0, 0);
        end
    endtask

    initial begin
        model_reset();
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0);

        fb_mode = 0;
        for (int h = 0; h < 8; h++) cyc(h, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0);
        idle(3);

        fb_mode = 2;
        for (int l = 0; l < 20; l++)
            rand_line(int'($urandom_range(0, VR - 1)), 24);
        idle(3);

        fb_mode = 1;
        cyc(0, 5, 1, 0, 0, 1, 0, 0, 0, 0, 0);
        cyc(1, 5, 1, 0, 0, 1, 1, 5, 'hF0A, 0, 0);
        cyc(2, 5, 1, 0, 0, 1, 0, 0, 0, 0, 0);
        cyc(3, 5, 1, 0, 0, 1, 0, 0, 0, 0, 0);
        idle(3);

        fb_mode = 2;
        cyc(40, 100, 1, 0, 0, 1, 0, 0, 0, 1, 470);
        cyc(0, 200, 1, 0, 0, 1, 0, 0, 0, 0, 0);
        chk("addr_pre_apply", fb_addr_o, 32000);
        cyc(0, VR, 0, 0, 1, 1, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0);
        chk("addr_scroll470", fb_addr_o, 75200);
        cyc(0, 10, 1, 0, 0, 1, 0, 0, 0, 0, 0);
        chk("addr_wrap", fb_addr_o, 0);
        cyc(5, 300, 1, 0, 0, 1, 0, 0, 0, 1, 480);
        cyc(0, VR, 0, 0, 1, 1, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0);
        chk("addr_ignore480", fb_addr_o, 75200);
        cyc(0, VR, 0, 0, 1, 1, 0, 0, 0, 1, 1);
        cyc(0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0);
        chk("addr_bypass", fb_addr_o, 160);
        idle(3);

        for (int h = 290; h <= 300; h++) cyc(h, 50, 1, 1, 1, 1, 0, 0, 0, 0, 0);
        #2;
        rstn_i = 1'b0;
        #1;
        chk("rst_r", r_o, 0);
        chk("rst_g", g_o, 0);
        chk("rst_b", b_o, 0);
        chk("rst_de", de_o, 0);
        chk("rst_hs", hsync_o, 0);
        chk("rst_vs", vsync_o, 0);
        model_reset();
        cyc(301, 50, 1, 1, 1, 0, 0, 0, 0, 0, 0);
        cyc(302, 50, 1, 1, 1, 0, 0, 0, 0, 0, 0);
        idle(2);
        fb_mode = 1;
        for (int h = 0; h < 6; h++) cyc(h, 0, 1, 1, 0, 1, 0, 0, 0, 0, 0);
        idle(3);

        fb_mode = 2;
        for (int l = 0; l < 10; l++)
            rand_line(int'($urandom_range(0, VR - 1)), 20);
        idle(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
